// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

   localparam int DEF_MAX_LEN = 8;
   localparam int DEF_CNT_W   = 8;

   typedef enum logic {WAIT, MATCH} state_t;

   // Pattern lengths outside 1..max_len are pulled back into range on load.
   function automatic int clamp_len(input int len, input int max_len);
      if (len < 1)
         return 1;
      if (len > max_len)
         return max_len;
      return len;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear on the same edge as an increment yields 1.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         r_count <= '0;
      else if (i_clr)
         r_count <= i_inc ? W'(1) : '0;
      else if (i_inc && (r_count != '1))
         r_count <= r_count + 1'b1;
   end

   assign o_count = r_count;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern, optional overlap,
// input-valid qualifier and a saturating match counter. Moore match flag.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int                 MAX_LEN     = DEF_MAX_LEN,
   parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
   parameter int                 CNT_W       = DEF_CNT_W,
   parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0000_1101),
   parameter int                 RST_LEN     = 4
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               i,
   input  logic               i_valid,
   input  logic               overlap_en,
   input  logic               load_pattern,
   input  logic [MAX_LEN-1:0] pattern_in,
   input  logic [LEN_W-1:0]   len_in,
   input  logic               count_clear,
   output logic               o,
   output logic [CNT_W-1:0]   match_count
);

   state_t             r_state, w_state_n;
   logic [MAX_LEN-1:0] r_pattern, r_hist, w_hist_n, w_mask;
   logic [LEN_W-1:0]   r_len, r_fill, w_fill_n, w_len_in;
   logic               w_accept, w_match_now;

   assign w_accept = i_valid && !load_pattern;
   assign w_hist_n = {r_hist[MAX_LEN-2:0], i};
   assign w_fill_n = (r_fill >= LEN_W'(MAX_LEN)) ? r_fill : r_fill + 1'b1;
   assign w_len_in = LEN_W'(clamp_len(int'(len_in), MAX_LEN));

   // Only the newest r_len history bits take part in the compare.
   assign w_mask      = ~({MAX_LEN{1'b1}} << r_len);
   assign w_match_now = w_accept && (w_fill_n >= r_len) &&
                        (((w_hist_n ^ r_pattern) & w_mask) == '0);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_pattern <= RST_PATTERN;
         r_len     <= LEN_W'(RST_LEN);
         r_hist    <= '0;
         r_fill    <= '0;
      end else if (load_pattern) begin
         r_pattern <= pattern_in;
         r_len     <= w_len_in;
         r_hist    <= '0;
         r_fill    <= '0;
      end else if (w_accept) begin
         r_hist <= w_hist_n;
         // Non-overlapping mode forces the next match to use fresh bits only.
         r_fill <= (w_match_now && !overlap_en) ? '0 : w_fill_n;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         r_state <= WAIT;
      else
         r_state <= w_state_n;
   end

   always_comb begin
      w_state_n = r_state;
      if (load_pattern)
         w_state_n = WAIT;
      else if (w_accept)
         w_state_n = w_match_now ? MATCH : WAIT;
   end

   assign o = (r_state == MATCH);

   sat_counter #(
      .W (CNT_W)
   ) u_cnt (
      .clk     (clk),
      .n_rst   (n_rst),
      .i_inc   (w_match_now),
      .i_clr   (count_clear),
      .o_count (match_count)
   );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: a default instance and a 2-bit
// counter instance share one stimulus stream and one behavioural model.
module tb_seq_detector_param;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       din, din_vld, ovl, ld, clr;
   logic [7:0] pat;
   logic [3:0] len;
   logic       o1, o2;
   logic [7:0] cnt1;
   logic [1:0] cnt2;

   int    n_tests = 0;
   int    n_fail  = 0;
   string phase   = "init";

   typedef struct {
      logic o;
      int   c8;
      int   c2;
      int   fill;
   } exp_t;
   exp_t sb[$];

   // Behavioural model: list of bits accepted since last reset/load/non-overlap match.
   bit         m_bits[$];
   logic [7:0] m_pat;
   int         m_len;
   logic       m_o;
   int         m_c8, m_c2;

   seq_detector_param u_dut (
      .clk(clk), .n_rst(n_rst), .i(din), .i_valid(din_vld), .overlap_en(ovl),
      .load_pattern(ld), .pattern_in(pat), .len_in(len), .count_clear(clr),
      .o(o1), .match_count(cnt1)
   );

   seq_detector_param #(.CNT_W(2)) u_dut2 (
      .clk(clk), .n_rst(n_rst), .i(din), .i_valid(din_vld), .overlap_en(ovl),
      .load_pattern(ld), .pattern_in(pat), .len_in(len), .count_clear(clr),
      .o(o2), .match_count(cnt2)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s/%s: got %0d expected %0d", phase, tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_bits.delete();
      m_pat = 8'b0000_1101;
      m_len = 4;
      m_o   = 1'b0;
      m_c8  = 0;
      m_c2  = 0;
   endtask

   task automatic tick();
      exp_t e;
      bit   mn;
      mn = 1'b0;
      if (ld) begin
         m_pat = pat;
         m_len = (len < 1) ? 1 : ((len > 8) ? 8 : int'(len));
         m_bits.delete();
         m_o = 1'b0;
      end else if (din_vld) begin
         m_bits.push_back(din);
         if (m_bits.size() > 8)
            void'(m_bits.pop_front());
         mn = (m_bits.size() >= m_len);
         for (int k = 0; k < m_len; k++)
            if (mn && (m_bits[m_bits.size()-1-k] != m_pat[k]))
               mn = 1'b0;
         m_o = mn;
         if (mn && !ovl)
            m_bits.delete();
      end
      if (clr) begin
         m_c8 = mn ? 1 : 0;
         m_c2 = mn ? 1 : 0;
      end else if (mn) begin
         m_c8 = (m_c8 == 255) ? 255 : m_c8 + 1;
         m_c2 = (m_c2 == 3) ? 3 : m_c2 + 1;
      end
      e.o = m_o; e.c8 = m_c8; e.c2 = m_c2; e.fill = m_bits.size();
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("o", 32'(o1), 32'(e.o));
      check("o2", 32'(o2), 32'(e.o));
      check("cnt", 32'(cnt1), e.c8);
      check("cnt2", 32'(cnt2), e.c2);
      check("fill", 32'(u_dut.r_fill), e.fill);
   endtask

   task automatic send(input bit b);
      din = b; din_vld = 1'b1; ld = 1'b0; clr = 1'b0;
      tick();
      din_vld = 1'b0;
   endtask

   task automatic idle(input int n);
      din_vld = 1'b0; ld = 1'b0; clr = 1'b0;
      for (int k = 0; k < n; k++)
         tick();
   endtask

   task automatic load(input logic [7:0] p, input logic [3:0] l);
      pat = p; len = l; ld = 1'b1; din_vld = 1'b0; clr = 1'b0;
      tick();
      ld = 1'b0;
   endtask

   task automatic send_seq(input logic [15:0] bits, input int n);
      logic [15:0] s;
      s = bits;
      for (int k = n - 1; k >= 0; k--)
         send(s[k]);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic areset();
      #2 n_rst = 1'b0;
      #1;
      check("rst_o", 32'(o1), 0);
      check("rst_cnt", 32'(cnt1), 0);
      check("rst_cnt2", 32'(cnt2), 0);
      model_reset();
      #2 n_rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_rst = 1'b0; din = 1'b0; din_vld = 1'b0; ovl = 1'b1; ld = 1'b0;
      clr = 1'b0; pat = '0; len = '0;
      model_reset();
      #12;
      phase = "reset";
      check("o", 32'(o1), 0);
      check("cnt", 32'(cnt1), 0);
      check("fill", 32'(u_dut.r_fill), 0);
      n_rst = 1'b1;
      @(posedge clk);
      #1;

      phase = "overlap";
      ovl = 1'b1;
      send_seq(16'b1101, 4);
      check("o_bit4", 32'(o1), 1);
      send(1'b1);
      check("o_bit5", 32'(o1), 0);
      send(1'b0);
      check("o_bit6", 32'(o1), 0);
      send(1'b1);
      check("o_bit7", 32'(o1), 1);
      check("cnt_end", 32'(cnt1), 2);

      areset();
      phase = "nonoverlap";
      ovl = 1'b0;
      send_seq(16'b1101, 4);
      check("o_bit4", 32'(o1), 1);
      send_seq(16'b101, 3);
      check("o_bit7", 32'(o1), 0);
      check("fill_bit7", 32'(u_dut.r_fill), 3);
      check("cnt_end", 32'(cnt1), 1);

      areset();
      phase = "len8";
      ovl = 1'b1;
      load(8'b1010_1010, 4'd8);
      send_seq(16'b1010_1010, 8);
      check("o_bit8", 32'(o1), 1);
      send_seq(16'b10, 2);
      check("o_bit10", 32'(o1), 1);
      check("cnt_end", 32'(cnt1), 2);

      areset();
      phase = "gaps";
      send(1'b1); send(1'b1);
      idle(3);
      send(1'b0); send(1'b1);
      check("o_rise", 32'(o1), 1);
      idle(5);
      check("o_hold", 32'(o1), 1);
      send(1'b0);
      check("o_drop", 32'(o1), 0);

      areset();
      phase = "load_vs_valid";
      send_seq(16'b110, 3);
      pat = 8'b0000_1101; len = 4'd4; ld = 1'b1; din = 1'b1; din_vld = 1'b1;
      tick();
      ld = 1'b0; din_vld = 1'b0;
      check("fill0", 32'(u_dut.r_fill), 0);
      check("o0", 32'(o1), 0);
      send(1'b1);
      check("no_match", 32'(o1), 0);
      send_seq(16'b1101, 4);
      check("fresh_match", 32'(o1), 1);

      areset();
      phase = "sat";
      load(8'b0000_0001, 4'd1);
      for (int k = 0; k < 5; k++)
         send(1'b1);
      check("cnt2_sat", 32'(cnt2), 3);
      check("cnt_5", 32'(cnt1), 5);
      din = 1'b1; din_vld = 1'b1; clr = 1'b1;
      tick();
      clr = 1'b0; din_vld = 1'b0;
      check("clr_match", 32'(cnt2), 1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_alone", 32'(cnt2), 0);
      send(1'b0);
      check("len1_zero", 32'(o1), 0);
      send(1'b1);
      send(1'b1);
      areset();

      phase = "clamp";
      ovl = 1'b0;
      load(8'b0000_0000, 4'd0);
      send(1'b0);
      check("len0_match", 32'(o1), 1);
      send(1'b0);
      check("len0_again", 32'(o1), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised successor to the team's fixed 1101 Moore detector.
- Serial-bit pattern detector with a runtime-programmable pattern (1..MAX_LEN bits), selectable overlapping or non-overlapping detection, an input-valid qualifier, and a saturating match counter.
- Sits on a serial input stream. Drives a registered Moore match flag and a count to downstream control/status logic.
- Out of reset it detects 1101 with overlap.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2)
- LEN_W, $clog2(MAX_LEN+1), width of the length field
- CNT_W, 8, match counter width
- RST_PATTERN, 8'b0000_1101, pattern loaded at reset (LSB-aligned)
- RST_LEN, 4, pattern length loaded at reset

Ports:
- clk  input  1  system clock, all state on rising edge
- n_rst  input  1  asynchronous active-low reset
- i  input  1  serial data bit
- i_valid  input  1  i is accepted on this edge when high
- overlap_en  input  1  1 = overlapping matches, 0 = non-overlapping
- load_pattern  input  1  single-cycle strobe; samples pattern_in/len_in
- pattern_in  input  MAX_LEN  new pattern, LSB-aligned; bit [len-1] is the first bit expected on the wire
- len_in  input  LEN_W  new pattern length
- count_clear  input  1  synchronous clear of match_count
- o  output  1  Moore match flag
- match_count  output  CNT_W  saturating number of matches

Behaviour:
- Reset (async, n_rst=0) sets:
  - pattern_q = RST_PATTERN, len_q = RST_LEN
  - hist = 0, fill = 0, state = WAIT, o = 0, match_count = 0
- Registers:
  - hist: MAX_LEN-bit shift register of accepted bits; the newest bit enters at bit 0.
  - fill: 0..MAX_LEN, saturating count of bits accepted since the last reset, load, or non-overlap match.
- Bit acceptance (i_valid=1, load_pattern=0):
  - hist_n = {hist[MAX_LEN-2:0], i}
  - fill_n = min(fill+1, MAX_LEN)
  - match_now = (fill_n >= len_q) && (hist_n[len_q-1:0] == pattern_q[len_q-1:0])
- State machine, two states, Moore, o = (state == MATCH):
  - On an accepted bit, go to MATCH if match_now, else WAIT (this applies from both states).
  - With no accepted bit, hold the state. o therefore stays high until the next accepted bit.
  - Latency: o rises on the clock edge that accepts the final pattern bit, i.e. one cycle after that bit is presented.
- Overlap:
  - overlap_en is sampled on the accepting edge.
  - If match_now && !overlap_en, fill is set to 0 instead of fill_n. The next match then needs len_q fresh bits.
  - If overlap_en=1, fill keeps fill_n, so a suffix of the match may begin the next match.
- Load:
  - When load_pattern=1, on that edge: pattern_q = pattern_in, len_q = clamp(len_in, 1, MAX_LEN), fill = 0, hist = 0, state = WAIT.
  - load_pattern has priority over i_valid; the simultaneous bit is discarded.
  - match_count is unaffected by a load.
- Counter:
  - Increments by 1 on each edge where match_now is true, saturating at 2^CNT_W-1.
  - If count_clear and match_now occur on the same edge, match_count becomes 1.
  - If count_clear occurs alone, match_count becomes 0.
- len_q = 1: every accepted bit equal to pattern_q[0] is a match, in both modes.
- With i_valid low, hist, fill, state, o and match_count are all held.
- Reset mid-stream: all state returns to reset values immediately; there is no partial-match carry-over.

Decomposition:
- Package seq_det_pkg:
  - state enum {WAIT, MATCH}
  - default MAX_LEN/CNT_W constants
  - a clamp_len function
- Sub-module sat_counter #(W): inc, clr, count; clear-then-increment semantics. It holds match_count.
- Pattern/history compare and the FSM stay in the top module.

Test Plan:
- Reset defaults, overlap_en=1, stream 1,1,0,1,1,0,1 (all valid):
  - o high after bits 4 and 7
  - match_count = 2
  - o low after bits 5 and 6
- Same stream, overlap_en=0:
  - o high only after bit 4
  - match_count = 1
  - fill reaches 3 at bit 7 with no match
- Load pattern_in=8'b1010_1010, len_in=8, overlap_en=1, send 1010101010:
  - matches after bits 8 and 10
  - match_count = 2
- Gaps in i_valid: send 1,1,(gap x3),0,1:
  - o rises after the final 1
  - o stays high through 5 idle cycles
  - o drops after the next accepted 0
- load_pattern and i_valid asserted together mid-stream:
  - the bit is discarded and fill = 0
  - o = 0
  - a new full pattern is needed before the next match
- CNT_W=2, len=1, pattern=1, send 5 ones:
  - count saturates at 3
  - count_clear on a matching edge gives 1
  - count_clear alone gives 0
  - async reset mid-stream gives o = 0 and count = 0 immediately
